// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the ALU issue/writeback slice: opcodes, FSM states,
// and a small opcode classification helper.
package alu_exec_ctrl_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_WB    = 2'b11
  } state_t;

  // Only add/sub can produce a signed overflow; logic ops never set V.
  function automatic logic op_is_arith(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational two's-complement ALU: add, sub, and, or with signed overflow.
// Outputs are forced to zero while enable is low.
module alu
  import alu_exec_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       control,
  input  logic             enable,
  output logic [WIDTH-1:0] dOut,
  output logic             overflow
);

  logic signed [WIDTH-1:0] w_a;
  logic signed [WIDTH-1:0] w_b;
  logic signed [WIDTH-1:0] w_sum;
  logic signed [WIDTH-1:0] w_diff;

  assign w_a    = a;
  assign w_b    = b;
  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;

  // Select the operation result and its signed-overflow indication.
  always_comb begin
    dOut     = '0;
    overflow = 1'b0;
    if (enable) begin
      case (control)
        OP_ADD: begin
          dOut     = w_sum;
          overflow = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
        end
        OP_SUB: begin
          dOut     = w_diff;
          overflow = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
        end
        OP_AND:  dOut = a & b;
        default: dOut = a | b;
      endcase
    end
  end

endmodule

// File: rtl/alu_regfile.sv
// Architectural register file: two operand read ports, one debug read port,
// and two write ports where the writeback port overrides the external load.
module alu_regfile #(
  parameter int WIDTH  = 8,
  parameter int REGS   = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  output logic [WIDTH-1:0]  o_rs1_data,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  output logic [WIDTH-1:0]  o_rs2_data,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [WIDTH-1:0]  o_dbg_data,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [WIDTH-1:0]  i_wb_data,
  input  logic              i_ld_en,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [WIDTH-1:0]  i_ld_data
);

  logic [WIDTH-1:0] r_mem [REGS];

  assign o_rs1_data = r_mem[i_rs1_addr];
  assign o_rs2_data = r_mem[i_rs2_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

  // Per-entry write: writeback wins over a load to the same address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REGS; i++) begin
        if (i_wb_en && (i_wb_addr == ADDR_W'(i))) begin
          r_mem[i] <= i_wb_data;
        end else if (i_ld_en && (i_ld_addr == ADDR_W'(i))) begin
          r_mem[i] <= i_ld_data;
        end
      end
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Issue/writeback controller around an external combinational ALU.
// One instruction per handshake walks IDLE -> FETCH -> EXEC -> WB; the result
// and flags become visible in WB and are written back to the register file.
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int REGS   = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [1:0]        alu_control,
  output logic              alu_enable,
  input  logic [WIDTH-1:0]  alu_dout,
  input  logic              alu_overflow,
  output logic              result_valid,
  output logic [WIDTH-1:0]  result_data,
  output logic [ADDR_W-1:0] result_rd,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v
);

  state_t r_state;
  state_t w_next;

  logic                    w_accept;
  logic                    w_wb_en;
  logic [WIDTH-1:0]        w_rs1_data;
  logic [WIDTH-1:0]        w_rs2_data;

  logic [1:0]              r_op_p0;
  logic [ADDR_W-1:0]       r_rd_p0;
  logic [ADDR_W-1:0]       r_rs1_p0;
  logic [ADDR_W-1:0]       r_rs2_p0;

  logic [WIDTH-1:0]        r_alu_a_p1;
  logic [WIDTH-1:0]        r_alu_b_p1;
  logic [1:0]              r_alu_ctrl_p1;
  logic [ADDR_W-1:0]       r_rd_p1;

  logic signed [WIDTH-1:0] r_res_p2;
  logic [ADDR_W-1:0]       r_rd_p2;
  logic                    r_z_p2;
  logic                    r_n_p2;
  logic                    r_v_p2;

  assign w_accept = instr_valid & instr_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: only IDLE waits; every other state lasts one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_FETCH;
      S_FETCH: w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded control outputs.
  always_comb begin
    instr_ready  = 1'b0;
    alu_enable   = 1'b0;
    result_valid = 1'b0;
    w_wb_en      = 1'b0;
    case (r_state)
      S_IDLE:  instr_ready = 1'b1;
      S_EXEC:  alu_enable  = 1'b1;
      S_WB: begin
        result_valid = 1'b1;
        w_wb_en      = 1'b1;
      end
      default: ;
    endcase
  end

  // Stage p0: latch the accepted instruction fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_p0  <= '0;
      r_rd_p0  <= '0;
      r_rs1_p0 <= '0;
      r_rs2_p0 <= '0;
    end else if (w_accept) begin
      r_op_p0  <= instr_op;
      r_rd_p0  <= instr_rd;
      r_rs1_p0 <= instr_rs1;
      r_rs2_p0 <= instr_rs2;
    end
  end

  // Stage p1: read and freeze operands for the ALU during FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a_p1    <= '0;
      r_alu_b_p1    <= '0;
      r_alu_ctrl_p1 <= '0;
      r_rd_p1       <= '0;
    end else if (r_state == S_FETCH) begin
      r_alu_a_p1    <= w_rs1_data;
      r_alu_b_p1    <= w_rs2_data;
      r_alu_ctrl_p1 <= r_op_p0;
      r_rd_p1       <= r_rd_p0;
    end
  end

  // Stage p2: capture ALU result and flags at the end of EXEC so they are presented in WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_p2 <= '0;
      r_rd_p2  <= '0;
      r_z_p2   <= 1'b0;
      r_n_p2   <= 1'b0;
      r_v_p2   <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_res_p2 <= alu_dout;
      r_rd_p2  <= r_rd_p1;
      r_z_p2   <= (alu_dout == '0);
      r_n_p2   <= alu_dout[WIDTH-1];
      r_v_p2   <= alu_overflow & op_is_arith(r_alu_ctrl_p1);
    end
  end

  assign alu_a       = r_alu_a_p1;
  assign alu_b       = r_alu_b_p1;
  assign alu_control = r_alu_ctrl_p1;
  assign result_data = r_res_p2;
  assign result_rd   = r_rd_p2;
  assign flag_z      = r_z_p2;
  assign flag_n      = r_n_p2;
  assign flag_v      = r_v_p2;

  alu_regfile #(
    .WIDTH  (WIDTH),
    .REGS   (REGS),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rs1_addr (r_rs1_p0),
    .o_rs1_data (w_rs1_data),
    .i_rs2_addr (r_rs2_p0),
    .o_rs2_data (w_rs2_data),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data),
    .i_wb_en    (w_wb_en),
    .i_wb_addr  (r_rd_p2),
    .i_wb_data  (r_res_p2),
    .i_ld_en    (ld_en),
    .i_ld_addr  (ld_addr),
    .i_ld_data  (ld_data)
  );

endmodule
